// File: rtl/uart_tx_arb.sv
// Two-channel FIFO-to-UART byte arbiter with burst-limited round-robin grant.
// Latency: FIFO seen non-empty in IDLE -> pop strobe next cycle -> tx_valid the cycle after.
// Backpressure: tx_valid/tx_data/grant hold until tx_ready; no FIFO pop while a byte is pending.
//
// Ports:
//   CLK, RST_N           clock, asynchronous active-low reset
//   enable               allow new grants (in-flight bytes always complete)
//   fifoN_empty/_data    channel N FIFO status and head word (N = 0, 1)
//   fifoN_rd             one-cycle pop strobe, only in FETCH for the granted channel
//   tx_valid/_data/_ready  byte handshake towards the UART transmitter
//   grant                one-hot owner (bit0 = ch0, bit1 = ch1), 00 when idle
//   busy                 FSM not in IDLE
module uart_tx_arb #(
    parameter int BURST_MAX = 4,
    parameter int WIDTH     = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             enable,
    input  logic             fifo0_empty,
    input  logic [WIDTH-1:0] fifo0_data,
    output logic             fifo0_rd,
    input  logic             fifo1_empty,
    input  logic [WIDTH-1:0] fifo1_data,
    output logic             fifo1_rd,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ready,
    output logic [1:0]       grant,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    localparam logic [3:0] L_BURST_MAX = 4'(BURST_MAX);

    state_t           r_state;
    logic [1:0]       r_grant;
    logic             r_last_owner;   // 0 = ch0, 1 = ch1
    logic [3:0]       r_burst_cnt;
    logic             r_tx_valid;
    logic [WIDTH-1:0] r_tx_data;

    logic             w_any_req;
    logic             w_pick_ch1;
    logic             w_gnt_empty;
    logic [WIDTH-1:0] w_gnt_data;
    logic [3:0]       w_cnt_nxt;
    logic             w_handshake;
    logic             w_continue;

    assign w_any_req   = !fifo0_empty || !fifo1_empty;
    // Prefer the channel that did not own the last burst; fall back to the
    // previous owner only when the other one has nothing to send.
    assign w_pick_ch1  = r_last_owner ? fifo0_empty : !fifo1_empty;
    assign w_gnt_empty = r_grant[1] ? fifo1_empty : fifo0_empty;
    assign w_gnt_data  = r_grant[1] ? fifo1_data  : fifo0_data;
    assign w_cnt_nxt   = r_burst_cnt + 4'd1;
    assign w_handshake = r_tx_valid && tx_ready;
    // Stay on the same channel only while the burst has room, arbitration is
    // enabled and the owner still has data; otherwise release the grant.
    assign w_continue  = (w_cnt_nxt < L_BURST_MAX) && enable && !w_gnt_empty;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_IDLE;
            r_grant      <= 2'b00;
            r_last_owner <= 1'b1;
            r_burst_cnt  <= 4'd0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_any_req) begin
                        r_grant <= w_pick_ch1 ? 2'b10 : 2'b01;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Pop strobe is high this cycle; capture the head word
                    // on the same edge the FIFO advances.
                    r_tx_data  <= w_gnt_data;
                    r_tx_valid <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_handshake) begin
                        r_tx_valid <= 1'b0;
                        if (w_continue) begin
                            r_burst_cnt <= w_cnt_nxt;
                            r_state     <= ST_FETCH;
                        end else begin
                            r_last_owner <= r_grant[1];
                            r_grant      <= 2'b00;
                            r_burst_cnt  <= 4'd0;
                            r_state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_grant    <= 2'b00;
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end

    // Pops are decoded from registered state so they clear instantly on reset
    // and can never fire for both channels at once (grant is one-hot).
    assign fifo0_rd = (r_state == ST_FETCH) && r_grant[0];
    assign fifo1_rd = (r_state == ST_FETCH) && r_grant[1];
    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign grant    = r_grant;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queue-backed FIFO models and an output scoreboard.
// Latency: checks pop/valid timing of the first byte and burst rotation order.
// Backpressure: holds tx_ready low and checks the offered byte stays put.
module tb_uart_tx_arb;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         enable = 1'b0;
    logic         fifo0_empty, fifo1_empty;
    logic [W-1:0] fifo0_data, fifo1_data;
    logic         fifo0_rd, fifo1_rd;
    logic         tx_valid;
    logic [W-1:0] tx_data;
    logic         tx_ready = 1'b0;
    logic [1:0]   grant;
    logic         busy;

    typedef struct packed {
        logic [1:0]   gnt;
        logic [W-1:0] dat;
    } exp_t;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    exp_t         exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int rd0_cnt = 0;
    int rd1_cnt = 0;

    uart_tx_arb #(.BURST_MAX(4), .WIDTH(W)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .enable      (enable),
        .fifo0_empty (fifo0_empty),
        .fifo0_data  (fifo0_data),
        .fifo0_rd    (fifo0_rd),
        .fifo1_empty (fifo1_empty),
        .fifo1_data  (fifo1_data),
        .fifo1_rd    (fifo1_rd),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant       (grant),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic update_pins();
        fifo0_empty = (q0.size() == 0);
        fifo1_empty = (q1.size() == 0);
        fifo0_data  = (q0.size() != 0) ? q0[0] : '0;
        fifo1_data  = (q1.size() != 0) ? q1[0] : '0;
    endtask

    task automatic expect_byte(input logic [1:0] g, input logic [W-1:0] d);
        exp_t e;
        e.gnt = g;
        e.dat = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // FIFO model: a pop strobe seen before an edge removes the head just
    // after that edge, so the DUT latches the old head on the pop edge.
    initial begin
        logic p0, p1;
        forever begin
            @(negedge CLK);
            p0 = fifo0_rd;
            p1 = fifo1_rd;
            @(posedge CLK);
            #1;
            if (RST_N) begin
                if (p0 && q0.size() != 0) void'(q0.pop_front());
                if (p1 && q1.size() != 0) void'(q1.pop_front());
                update_pins();
            end
        end
    end

    // Monitor: pop legality and scoreboard compare on each handshake.
    always @(negedge CLK) begin
        if (fifo0_rd || fifo1_rd) begin
            chk("rd_onehot", {31'd0, fifo0_rd & fifo1_rd}, 0);
        end
        if (fifo0_rd) begin
            rd0_cnt++;
            chk("rd0_grant", {30'd0, grant}, 2'b01);
            chk("rd0_underflow", {31'd0, fifo0_empty}, 0);
        end
        if (fifo1_rd) begin
            rd1_cnt++;
            chk("rd1_grant", {30'd0, grant}, 2'b10);
            chk("rd1_underflow", {31'd0, fifo1_empty}, 0);
        end
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                chk("tx_unexpected", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("tx_data", {24'd0, tx_data}, {24'd0, e.dat});
                chk("tx_grant", {30'd0, grant}, {30'd0, e.gnt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int base0, base1, n;
        update_pins();

        // Reset state
        #12;
        chk("rst_tx_valid", {31'd0, tx_valid}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        chk("rst_grant", {30'd0, grant}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rd", {30'd0, fifo1_rd, fifo0_rd}, 0);
        @(negedge CLK);
        RST_N    = 1'b1;
        enable   = 1'b1;
        tx_ready = 1'b1;

        // Fairness: 10 bytes each, bursts of 4 alternate starting with ch0
        base0 = rd0_cnt;
        base1 = rd1_cnt;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 10; i++) begin
            q0.push_back(8'(i));
            q1.push_back(8'(8'h80 + i));
        end
        update_pins();
        for (int b = 0; b < 3; b++) begin
            int len;
            len = (b == 2) ? 2 : 4;
            for (int k = 0; k < len; k++) expect_byte(2'b01, 8'(b * 4 + k));
            for (int k = 0; k < len; k++) expect_byte(2'b10, 8'(8'h80 + b * 4 + k));
        end
        wait_done("fair", 400);
        chk("fair_rd0_cnt", rd0_cnt - base0, 10);
        chk("fair_rd1_cnt", rd1_cnt - base1, 10);

        // Single byte latency on ch0
        base0 = rd0_cnt;
        @(posedge CLK);
        #1;
        q0.push_back(8'hA5);
        update_pins();
        expect_byte(2'b01, 8'hA5);
        @(negedge CLK);
        chk("single_rd_early", {31'd0, fifo0_rd}, 0);
        @(negedge CLK);
        chk("single_rd", {31'd0, fifo0_rd}, 1);
        chk("single_grant", {30'd0, grant}, 2'b01);
        chk("single_valid_early", {31'd0, tx_valid}, 0);
        @(negedge CLK);
        chk("single_valid", {31'd0, tx_valid}, 1);
        chk("single_data", {24'd0, tx_data}, 8'hA5);
        chk("single_rd_after", {31'd0, fifo0_rd}, 0);
        @(negedge CLK);
        chk("single_grant_idle", {30'd0, grant}, 0);
        chk("single_busy", {31'd0, busy}, 0);
        chk("single_valid_drop", {31'd0, tx_valid}, 0);
        chk("single_rd_cnt", rd0_cnt - base0, 1);

        // Disable during second byte of a ch1 burst
        base1 = rd1_cnt;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            q1.push_back(8'(8'h51 + i));
            expect_byte(2'b10, 8'(8'h51 + i));
        end
        update_pins();
        n = 0;
        while (!(tx_valid && rd1_cnt == base1 + 2) && n < 20) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk("dis_second_byte", rd1_cnt - base1, 2);
        enable = 1'b0;
        repeat (6) @(negedge CLK);
        #1;
        chk("dis_grant", {30'd0, grant}, 0);
        chk("dis_busy", {31'd0, busy}, 0);
        chk("dis_no_rd", rd1_cnt - base1, 2);
        chk("dis_sent", exp_q.size(), 2);
        chk("dis_left", q1.size(), 2);
        enable = 1'b1;
        wait_done("dis_resume", 100);
        chk("dis_rd_total", rd1_cnt - base1, 4);

        // Empty mid-burst: ch0 x2 then ch1 x1
        @(posedge CLK);
        #1;
        q0.push_back(8'h61);
        q0.push_back(8'h62);
        q1.push_back(8'h71);
        update_pins();
        expect_byte(2'b01, 8'h61);
        expect_byte(2'b01, 8'h62);
        expect_byte(2'b10, 8'h71);
        wait_done("empty_mid", 100);

        // Backpressure: 7 edges of tx_ready=0 while 0x3C is offered
        @(posedge CLK);
        #1;
        tx_ready = 1'b0;
        q0.push_back(8'h3C);
        update_pins();
        expect_byte(2'b01, 8'h3C);
        n = 0;
        while (!tx_valid && n < 10) begin
            @(posedge CLK);
            #1;
            n++;
        end
        base0 = rd0_cnt;
        for (int i = 0; i < 7; i++) begin
            @(posedge CLK);
            #1;
            chk("bp_valid", {31'd0, tx_valid}, 1);
            chk("bp_data", {24'd0, tx_data}, 8'h3C);
        end
        chk("bp_no_rd", rd0_cnt - base0, 0);
        tx_ready = 1'b1;
        wait_done("bp", 20);
        chk("bp_no_rd_after", rd0_cnt - base0, 0);

        // Reset while a ch1 byte is in SEND
        @(posedge CLK);
        #1;
        tx_ready = 1'b0;
        q0.push_back(8'h90);
        q1.push_back(8'hA0);
        update_pins();
        n = 0;
        while (!tx_valid && n < 10) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("rsend_grant", {30'd0, grant}, 2'b10);
        chk("rsend_data", {24'd0, tx_data}, 8'hA0);
        #2;
        RST_N = 1'b0;
        #1;
        chk("rsend_valid", {31'd0, tx_valid}, 0);
        chk("rsend_tx_data", {24'd0, tx_data}, 0);
        chk("rsend_grant0", {30'd0, grant}, 0);
        chk("rsend_busy", {31'd0, busy}, 0);
        chk("rsend_rd", {30'd0, fifo1_rd, fifo0_rd}, 0);
        q1.push_back(8'hA1);
        update_pins();
        expect_byte(2'b01, 8'h90);
        expect_byte(2'b10, 8'hA1);
        repeat (2) @(negedge CLK);
        chk("rsend_hold_busy", {31'd0, busy}, 0);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("rsend_first_grant", {30'd0, grant}, 2'b01);
        chk("rsend_first_rd", {31'd0, fifo0_rd}, 1);
        tx_ready = 1'b1;
        wait_done("rsend_restart", 50);
        chk("end_q0", q0.size(), 0);
        chk("end_q1", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter BURST_MAX, default 4: maximum bytes sent per grant before rotating to the other channel (legal range 1..15).
REQ-002 SHALL have parameter WIDTH, default 8: data byte width.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  1 = arbitration allowed; 0 = no new grants.
REQ-006 fifo0_empty  input  1  channel-0 FIFO empty flag.
REQ-007 fifo0_data  input  WIDTH  channel-0 FIFO head word, combinationally valid while fifo0_empty=0.
REQ-008 fifo0_rd  output  1  one-cycle pop strobe to the channel-0 FIFO.
REQ-009 fifo1_empty, fifo1_data, fifo1_rd  same as REQ-006..008, for channel 1.
REQ-010 tx_valid  output  1  byte offered to the UART transmitter.
REQ-011 tx_data  output  WIDTH  byte offered; registered.
REQ-012 tx_ready  input  1  transmitter accepts the byte when tx_valid=1 and tx_ready=1 on a rising edge.
REQ-013 grant  output  2  one-hot current owner (bit0 = ch0, bit1 = ch1); 2'b00 when idle.
REQ-014 busy  output  1  1 whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, FETCH and SEND; the state is encoded in registers.
REQ-016 IDLE: if enable=1 and at least one fifoN_empty=0, the block SHALL set grant and move to FETCH on the next edge; otherwise it SHALL stay in IDLE.
REQ-017 Channel choice: the non-empty channel not equal to last_owner wins; if only last_owner is non-empty, it wins. last_owner resets to ch1, so ch0 wins the first tie.
REQ-018 FETCH lasts exactly one cycle: fifoN_rd=1 for the granted N only (combinational from state and grant), tx_data <= fifoN_data on that edge, next state SEND.
REQ-019 fifoN_rd SHALL never assert outside FETCH, never for a non-granted channel, and never for both channels in the same cycle.
REQ-020 SEND: tx_valid=1. tx_data and grant SHALL hold stable until the handshake; tx_valid SHALL not drop before the handshake, except on reset.
REQ-021 On the handshake edge, burst_cnt increments. If all of the following hold, next state is FETCH on the same channel:
- burst_cnt+1 < BURST_MAX
- enable=1
- granted fifoN_empty=0
REQ-022 Otherwise next state is IDLE, last_owner <= granted channel, grant <= 0, burst_cnt <= 0.
REQ-023 Latency: non-empty FIFO seen in IDLE at edge k -> fifo_rd high in cycle k+1 -> tx_valid high from edge k+2. Back-to-back bytes within a burst: one FETCH cycle gap between handshake and the next tx_valid.
REQ-024 burst_cnt SHALL be 4 bits and never exceed BURST_MAX-1.
REQ-025 enable falling in FETCH or SEND SHALL NOT abort the in-flight byte; the byte completes and the FSM then returns to IDLE.
REQ-026 A FIFO becoming empty mid-burst SHALL end the grant after the current byte. No underflow pop is possible, because fifo_rd asserts only after empty=0 is checked.
REQ-027 A channel whose FIFO is never empty SHALL NOT starve the other: after at most BURST_MAX bytes the grant rotates if the other channel is non-empty.

Reset
REQ-028 While RST_N=0, asynchronously:
- state=IDLE, grant=0, busy=0
- tx_valid=0, tx_data=0
- fifo0_rd=0, fifo1_rd=0
- burst_cnt=0, last_owner=ch1
REQ-029 Reset asserted mid-SEND SHALL drop tx_valid immediately. The byte already popped is discarded; no FIFO is re-read.
REQ-030 After RST_N deasserts, the first grant decision SHALL occur on the first rising edge with RST_N=1.

Verification
REQ-031 Single byte: ch0 holds 0xA5, ch1 empty, tx_ready=1.
- Expect one fifo0_rd pulse, then tx_valid with tx_data=0xA5 two cycles after the IDLE sample.
- Expect grant 01 -> 00, and busy=0 after the handshake.
REQ-032 Fairness: both FIFOs hold 10 bytes, BURST_MAX=4, tx_ready=1.
- Expect the output order ch0 x4, ch1 x4, ch0 x4, ch1 x4, ch0 x2, ch1 x2.
- Expect no double fifo_rd pulses.
REQ-033 Backpressure: tx_ready=0 for 7 cycles during SEND.
- Expect tx_valid and tx_data=0x3C held constant for all 7 cycles.
- Expect the byte accepted on the first tx_ready=1 edge, with no extra fifo_rd.
REQ-034 Disable mid-burst: enable=0 during the second byte of a ch1 burst.
- Expect that byte to complete.
- Expect the FSM in IDLE with grant=00, and no further fifo_rd while enable=0.
REQ-035 Empty mid-burst: ch0 holds 2 bytes, BURST_MAX=4, ch1 holds 1 byte.
- Expect ch0, ch0, then the grant moves to ch1 for its 1 byte.
REQ-036 Reset in SEND: assert RST_N=0 while tx_valid=1.
- Expect tx_valid=0 in the same cycle and all outputs at their REQ-028 values.
- After RST_N=1, expect arbitration to restart with ch0 preferred.
